// File: rtl/bp_fe_ras_ctrl.sv
// bp_fe_ras_ctrl: classifies calls/returns, drives RAS push/pop, tracks occupancy
// and registers a one-deep prediction (kind, taken, target) for the next fetch stage.
module bp_fe_ras_ctrl #(
  parameter int vaddr_width_p  = 39,
  parameter int ras_els_p      = 8,
  parameter int depth_width_lp = $clog2(ras_els_p+1)
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      fetch_v_i,
  output logic                      fetch_ready_o,
  input  logic [vaddr_width_p-1:0]  fetch_pc_i,
  input  logic [31:0]               fetch_instr_i,
  input  logic                      flush_i,
  output logic                      ras_push_o,
  output logic [vaddr_width_p-1:0]  ras_w_data_o,
  output logic                      ras_pop_o,
  input  logic [vaddr_width_p-1:0]  ras_r_data_i,
  output logic                      pred_v_o,
  input  logic                      pred_ready_i,
  output logic [vaddr_width_p-1:0]  pred_pc_o,
  output logic [1:0]                pred_kind_o,
  output logic                      pred_taken_o,
  output logic [vaddr_width_p-1:0]  pred_target_o,
  output logic [depth_width_lp-1:0] depth_o,
  output logic                      overflow_o
);
  logic [4:0] rd, rs1;
  logic is_jal, is_jalr, rd_link, rs1_link, call, ret, acc, full;
  logic [vaddr_width_p-1:0] jal_tgt;
  logic pred_v_d, pred_v_q, pred_taken_d, pred_taken_q, overflow_d, overflow_q;
  logic [vaddr_width_p-1:0] pred_pc_d, pred_pc_q, pred_target_d, pred_target_q;
  logic [1:0] pred_kind_d, pred_kind_q;
  logic [depth_width_lp-1:0] depth_d, depth_q;

  assign rd       = fetch_instr_i[11:7];
  assign rs1      = fetch_instr_i[19:15];
  assign is_jal   = fetch_instr_i[6:0] == 7'b1101111;
  assign is_jalr  = fetch_instr_i[6:0] == 7'b1100111 && fetch_instr_i[14:12] == 3'b000;
  assign rd_link  = rd == 5'd1 || rd == 5'd5;
  assign rs1_link = rs1 == 5'd1 || rs1 == 5'd5;
  // Coroutine swaps (both link, different regs) degrade to a plain return.
  assign call     = (is_jal & rd_link) | (is_jalr & rd_link & (~rs1_link | rd == rs1));
  assign ret      = is_jalr & rs1_link & (~rd_link | rd != rs1);
  assign jal_tgt  = fetch_pc_i + {{(vaddr_width_p-20){fetch_instr_i[31]}}, fetch_instr_i[19:12],
                                  fetch_instr_i[20], fetch_instr_i[30:21], 1'b0};
  assign full     = depth_q == depth_width_lp'(ras_els_p);

  assign fetch_ready_o = ~flush_i & (~pred_v_q | pred_ready_i);
  assign acc           = fetch_v_i & fetch_ready_o;
  assign ras_push_o    = ~reset_i & acc & call & ~full;
  assign ras_pop_o     = ~reset_i & acc & ret & depth_q != '0;
  assign ras_w_data_o  = fetch_pc_i + vaddr_width_p'(4);

  assign pred_v_o      = pred_v_q;
  assign pred_pc_o     = pred_pc_q;
  assign pred_kind_o   = pred_kind_q;
  assign pred_taken_o  = pred_taken_q;
  assign pred_target_o = pred_target_q;
  assign depth_o       = depth_q;
  assign overflow_o    = overflow_q;

  always_comb begin
    pred_v_d      = flush_i ? 1'b0 : acc ? 1'b1 : pred_v_q & ~pred_ready_i;
    pred_pc_d     = acc ? fetch_pc_i : pred_pc_q;
    pred_kind_d   = acc ? {ret, call} : pred_kind_q;
    pred_taken_d  = acc ? (is_jal | ras_pop_o) : pred_taken_q;
    pred_target_d = acc ? (is_jal ? jal_tgt : ras_pop_o ? ras_r_data_i : '0) : pred_target_q;
    depth_d       = depth_q + depth_width_lp'(ras_push_o) - depth_width_lp'(ras_pop_o);
    overflow_d    = acc & call & full;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      pred_v_q      <= 1'b0;
      pred_pc_q     <= '0;
      pred_kind_q   <= '0;
      pred_taken_q  <= 1'b0;
      pred_target_q <= '0;
      depth_q       <= '0;
      overflow_q    <= 1'b0;
    end else begin
      pred_v_q      <= pred_v_d;
      pred_pc_q     <= pred_pc_d;
      pred_kind_q   <= pred_kind_d;
      pred_taken_q  <= pred_taken_d;
      pred_target_q <= pred_target_d;
      depth_q       <= depth_d;
      overflow_q    <= overflow_d;
    end
  end
endmodule
